carpark_bay_ctrl: RTL and testbench



---
 rtl/carpark_bay_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_carpark_bay_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/carpark_bay_ctrl.sv
// -----------------------------------------------------------------------------
// carpark_bay_ctrl
//
// Car-park controller. It registers the per-bay occupancy sensors and derives
// the free-bay count from them. It also tracks cars that have been let in
// but have not yet appeared in a bay ("in flight"). Two independent barrier
// state machines drive the entry and exit gates.
//
// The entry barrier refuses a car while no bay is available, meaning every
// free bay is already claimed by an in-flight car. A gate stays open while
// its loop sensor is active. Once the loop clears, the gate stays open for
// exactly GATE_HOLD more cycles.
//
// Parameters
//   SLOTS      number of parking bays (1..64)
//   GATE_HOLD  cycles a barrier stays open after its loop clears (>=1)
//   CW         counter width, clog2(SLOTS+1) (derived, not overridable)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   bay_occ       bit i = 1: bay i occupied
//   entry_car     car present on entry loop (level)
//   exit_car      car present on exit loop (level)
//   entry_gate    1 = entry barrier open
//   exit_gate     1 = exit barrier open
//   free_cnt      unoccupied bays (1-cycle latency from bay_occ)
//   avail_cnt     free bays not claimed by in-flight cars
//   full          avail_cnt == 0
//   entry_denied  car waiting at entry while full (combinational)
// -----------------------------------------------------------------------------
module carpark_bay_ctrl #(
  parameter int SLOTS     = 4,
  parameter int GATE_HOLD = 4,
  localparam int CW       = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SLOTS-1:0] bay_occ,
  input  logic             entry_car,
  input  logic             exit_car,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic [CW-1:0]    free_cnt,
  output logic [CW-1:0]    avail_cnt,
  output logic             full,
  output logic             entry_denied
);

  // Hold counter only needs to hold GATE_HOLD-1.
  localparam int HW = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(GATE_HOLD - 1);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_OPEN = 2'd1;
  localparam logic [1:0] E_HOLD = 2'd2;

  localparam logic [1:0] X_IDLE = 2'd0;
  localparam logic [1:0] X_OPEN = 2'd1;
  localparam logic [1:0] X_HOLD = 2'd2;

  logic [SLOTS-1:0] bay_occ_reg;
  logic [CW-1:0]    inflight_reg;
  logic [CW-1:0]    inflight_next;

  logic [1:0]       entry_state_reg, entry_state_next;
  logic [HW-1:0]    entry_hold_reg, entry_hold_next;
  logic             entry_adm;

  logic [1:0]       exit_state_reg, exit_state_next;
  logic [HW-1:0]    exit_hold_reg, exit_hold_next;

  // ---------------------------------------------------------------------------
  // Popcounts as ripple prefix sums. The first term is the occupied count
  // from the registered sensors. The second term counts bays that became
  // occupied since the last sample. Because bay_occ_reg is cleared by reset,
  // every bay that is occupied on the first cycle after reset counts as
  // newly parked.
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0] bay_new;
  logic [CW-1:0]    occ_sum [SLOTS+1];
  logic [CW-1:0]    new_sum [SLOTS+1];

  assign bay_new    = bay_occ & ~bay_occ_reg;
  assign occ_sum[0] = '0;
  assign new_sum[0] = '0;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pop
      assign occ_sum[gi+1] = occ_sum[gi] + CW'(bay_occ_reg[gi]);
      assign new_sum[gi+1] = new_sum[gi] + CW'(bay_new[gi]);
    end
  endgenerate

  assign free_cnt  = CW'(SLOTS) - occ_sum[SLOTS];
  assign avail_cnt = (free_cnt > inflight_reg) ? (free_cnt - inflight_reg) : '0;
  assign full      = (avail_cnt == '0);

  // ---------------------------------------------------------------------------
  // In-flight tracking. An admission and a newly parked bay in the same
  // cycle are netted against each other. The sum is computed two bits wider
  // and signed, so that both underflow and overflow can be clamped.
  // ---------------------------------------------------------------------------
  logic signed [CW+1:0] infl_sum;

  always_comb begin
    infl_sum = $signed({2'b00, inflight_reg})
             + $signed({{(CW+1){1'b0}}, entry_adm})
             - $signed({2'b00, new_sum[SLOTS]});
    if (infl_sum < 0)
      inflight_next = '0;
    else if (infl_sum > $signed((CW+2)'(SLOTS)))
      inflight_next = CW'(SLOTS);
    else
      inflight_next = infl_sum[CW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Entry barrier. The gate is open for the OPEN cycle in which the loop
  // clears, plus GATE_HOLD-1 cycles in HOLD. That makes GATE_HOLD cycles in
  // total after the loop clears. If the loop reasserts during HOLD, it is
  // the same car, so no new admission is counted.
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_state_next = entry_state_reg;
    entry_hold_next  = entry_hold_reg;
    entry_adm        = 1'b0;
    case (entry_state_reg)
      E_IDLE: begin
        if (entry_car && !full) begin
          entry_state_next = E_OPEN;
          entry_adm        = 1'b1;
        end
      end
      E_OPEN: begin
        if (!entry_car) begin
          if (GATE_HOLD == 1) begin
            entry_state_next = E_IDLE;
          end else begin
            entry_state_next = E_HOLD;
            entry_hold_next  = HOLD_LOAD;
          end
        end
      end
      E_HOLD: begin
        if (entry_car)
          entry_state_next = E_OPEN;
        else if (entry_hold_reg <= HW'(1))
          entry_state_next = E_IDLE;
        else
          entry_hold_next = entry_hold_reg - HW'(1);
      end
      default: entry_state_next = E_IDLE;
    endcase
  end

  // Exit barrier: same timing as entry, but never refused and no admission.
  always_comb begin
    exit_state_next = exit_state_reg;
    exit_hold_next  = exit_hold_reg;
    case (exit_state_reg)
      X_IDLE: begin
        if (exit_car)
          exit_state_next = X_OPEN;
      end
      X_OPEN: begin
        if (!exit_car) begin
          if (GATE_HOLD == 1) begin
            exit_state_next = X_IDLE;
          end else begin
            exit_state_next = X_HOLD;
            exit_hold_next  = HOLD_LOAD;
          end
        end
      end
      X_HOLD: begin
        if (exit_car)
          exit_state_next = X_OPEN;
        else if (exit_hold_reg <= HW'(1))
          exit_state_next = X_IDLE;
        else
          exit_hold_next = exit_hold_reg - HW'(1);
      end
      default: exit_state_next = X_IDLE;
    endcase
  end

  assign entry_gate   = (entry_state_reg == E_OPEN) || (entry_state_reg == E_HOLD);
  assign exit_gate    = (exit_state_reg  == X_OPEN) || (exit_state_reg  == X_HOLD);
  assign entry_denied = (entry_state_reg == E_IDLE) && entry_car && full;

  always_ff @(posedge clk) begin
    if (rst) begin
      bay_occ_reg     <= '0;
      inflight_reg    <= '0;
      entry_state_reg <= E_IDLE;
      entry_hold_reg  <= '0;
      exit_state_reg  <= X_IDLE;
      exit_hold_reg   <= '0;
    end else begin
      bay_occ_reg     <= bay_occ;
      inflight_reg    <= inflight_next;
      entry_state_reg <= entry_state_next;
      entry_hold_reg  <= entry_hold_next;
      exit_state_reg  <= exit_state_next;
      exit_hold_reg   <= exit_hold_next;
    end
  end

endmodule

// File: tb/tb_carpark_bay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_carpark_bay_ctrl
//
// Directed testbench for carpark_bay_ctrl with SLOTS=4 and GATE_HOLD=2.
//
// Inputs are driven 1 time unit after each rising edge. Outputs are
// sampled on the following falling edge. Cycle 0 is the first cycle with
// rst low, after two reset edges. Every expected value below was worked
// out by hand, cycle by cycle.
// -----------------------------------------------------------------------------
module tb_carpark_bay_ctrl;

  localparam int SLOTS     = 4;
  localparam int GATE_HOLD = 2;
  localparam int CW        = $clog2(SLOTS + 1);

  logic             clk;
  logic             rst;
  logic [SLOTS-1:0] bay_occ;
  logic             entry_car;
  logic             exit_car;
  logic             entry_gate;
  logic             exit_gate;
  logic [CW-1:0]    free_cnt;
  logic [CW-1:0]    avail_cnt;
  logic             full;
  logic             entry_denied;

  int vec_cnt  = 0;
  int miscomp  = 0;
  int cyc_n    = -1;

  carpark_bay_ctrl #(
    .SLOTS     (SLOTS),
    .GATE_HOLD (GATE_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bay_occ      (bay_occ),
    .entry_car    (entry_car),
    .exit_car     (exit_car),
    .entry_gate   (entry_gate),
    .exit_gate    (exit_gate),
    .free_cnt     (free_cnt),
    .avail_cnt    (avail_cnt),
    .full         (full),
    .entry_denied (entry_denied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      miscomp++;
      $display("FAIL cyc %0d %s: got %0d expected %0d", cyc_n, tag, obs, exp);
    end
  endtask

  // Apply one cycle's inputs after the edge, then wait for the sampling point.
  task automatic cyc(input logic r, input logic e, input logic x,
                     input logic [SLOTS-1:0] b);
    @(posedge clk);
    #1;
    rst       = r;
    entry_car = e;
    exit_car  = x;
    bay_occ   = b;
    cyc_n++;
    @(negedge clk);
    $display("cyc %0d rst=%0b ent=%0b ext=%0b bay=%b | eg=%0b xg=%0b free=%0d avail=%0d full=%0b den=%0b",
             cyc_n, r, e, x, b, entry_gate, exit_gate, free_cnt, avail_cnt, full, entry_denied);
  endtask

  initial begin
    rst = 1'b1; entry_car = 1'b0; exit_car = 1'b0; bay_occ = '0;
    cyc_n = -2;
    cyc(1'b1, 1'b0, 1'b0, 4'b0000);

    // Reset state.
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c0
    check_val("rst_free",  int'(free_cnt), 4);
    check_val("rst_avail", int'(avail_cnt), 4);
    check_val("rst_full",  int'(full), 0);
    check_val("rst_eg",    int'(entry_gate), 0);
    check_val("rst_xg",    int'(exit_gate), 0);
    check_val("rst_den",   int'(entry_denied), 0);

    // Single admission and gate timing.
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);                                    // c1
    check_val("c1_eg",    int'(entry_gate), 0);
    check_val("c1_avail", int'(avail_cnt), 4);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);                                    // c2
    check_val("c2_eg",    int'(entry_gate), 1);
    check_val("c2_avail", int'(avail_cnt), 3);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);                                    // c3
    check_val("c3_eg", int'(entry_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c4
    check_val("c4_eg", int'(entry_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c5
    check_val("c5_eg", int'(entry_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c6
    check_val("c6_eg", int'(entry_gate), 0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c7
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);                                    // c8
    check_val("c8_free",  int'(free_cnt), 4);
    check_val("c8_avail", int'(avail_cnt), 3);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);                                    // c9
    check_val("c9_free",  int'(free_cnt), 3);
    check_val("c9_avail", int'(avail_cnt), 3);
    check_val("c9_full",  int'(full), 0);

    // Fill up and refuse entry, then release a bay.
    cyc(1'b0, 1'b0, 1'b0, 4'b0111);                                    // c10
    cyc(1'b0, 1'b1, 1'b0, 4'b0111);                                    // c11
    check_val("c11_free",  int'(free_cnt), 1);
    check_val("c11_avail", int'(avail_cnt), 1);
    check_val("c11_eg",    int'(entry_gate), 0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0111);                                    // c12
    check_val("c12_eg",    int'(entry_gate), 1);
    check_val("c12_avail", int'(avail_cnt), 0);
    check_val("c12_full",  int'(full), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0111);                                    // c13
    check_val("c13_eg", int'(entry_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0111);                                    // c14
    check_val("c14_eg", int'(entry_gate), 0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0111);                                    // c15
    check_val("c15_eg",   int'(entry_gate), 0);
    check_val("c15_den",  int'(entry_denied), 1);
    check_val("c15_full", int'(full), 1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0011);                                    // c16
    check_val("c16_eg",  int'(entry_gate), 0);
    check_val("c16_den", int'(entry_denied), 1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0011);                                    // c17
    check_val("c17_free",  int'(free_cnt), 2);
    check_val("c17_avail", int'(avail_cnt), 1);
    check_val("c17_den",   int'(entry_denied), 0);
    check_val("c17_eg",    int'(entry_gate), 0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0011);                                    // c18
    check_val("c18_eg",    int'(entry_gate), 1);
    check_val("c18_avail", int'(avail_cnt), 0);
    check_val("c18_full",  int'(full), 1);

    // Loop drops for one cycle during HOLD: same car, one admission only.
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);                                    // c19
    check_val("c19_eg", int'(entry_gate), 1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0011);                                    // c20
    check_val("c20_eg", int'(entry_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c21
    check_val("c21_eg", int'(entry_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c22
    check_val("c22_eg",    int'(entry_gate), 1);
    check_val("c22_free",  int'(free_cnt), 4);
    check_val("c22_avail", int'(avail_cnt), 2);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);                                    // c23
    check_val("c23_eg",    int'(entry_gate), 0);
    check_val("c23_avail", int'(avail_cnt), 2);

    // Admission netted against a newly parked bay; entry and exit together.
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);                                    // c24
    check_val("c24_avail", int'(avail_cnt), 2);
    cyc(1'b0, 1'b1, 1'b1, 4'b0011);                                    // c25
    check_val("c25_free",  int'(free_cnt), 3);
    check_val("c25_avail", int'(avail_cnt), 2);
    check_val("c25_xg",    int'(exit_gate), 0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);                                    // c26
    check_val("c26_free",  int'(free_cnt), 2);
    check_val("c26_avail", int'(avail_cnt), 1);
    check_val("c26_eg",    int'(entry_gate), 1);
    check_val("c26_xg",    int'(exit_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);                                    // c27
    check_val("c27_eg", int'(entry_gate), 1);
    check_val("c27_xg", int'(exit_gate), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);                                    // c28
    check_val("c28_eg", int'(entry_gate), 0);
    check_val("c28_xg", int'(exit_gate), 0);

    // Reset while the entry gate is open and two cars are in flight.
    cyc(1'b0, 1'b1, 1'b0, 4'b0011);                                    // c29
    check_val("c29_avail", int'(avail_cnt), 1);
    cyc(1'b1, 1'b1, 1'b0, 4'b0011);                                    // c30
    check_val("c30_eg",    int'(entry_gate), 1);
    check_val("c30_avail", int'(avail_cnt), 0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);                                    // c31
    check_val("c31_eg",    int'(entry_gate), 0);
    check_val("c31_xg",    int'(exit_gate), 0);
    check_val("c31_free",  int'(free_cnt), 4);
    check_val("c31_avail", int'(avail_cnt), 4);
    check_val("c31_full",  int'(full), 0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);                                    // c32
    check_val("c32_free",  int'(free_cnt), 2);
    check_val("c32_avail", int'(avail_cnt), 2);
    check_val("c32_eg",    int'(entry_gate), 0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0011);                                    // c33
    check_val("c33_eg", int'(entry_gate), 0);
    check_val("c33_xg", int'(exit_gate), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule
